nnrv_regfile: RTL and testbench

//  Integer register file (x0..x31) for the nnrv core. Sink of the writeback-stage

---
 rtl/nnrv_pkg.sv | 17 +
 rtl/nnrv_regfile_rdport.sv | 58 +++++
 rtl/nnrv_regfile.sv | 81 ++++++++
 tb/tb_nnrv_regfile.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/nnrv_pkg.sv
// Shared definitions for the nnrv core: data width defaults, register index
// type and the hardwired-zero register helper.
package nnrv_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int NREGS_DEF = 32;
  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  localparam reg_idx_t REG_ZERO = 5'd0;

  function automatic logic reg_is_zero(input reg_idx_t idx);
    return (idx == REG_ZERO);
  endfunction

endpackage

// File: rtl/nnrv_regfile_rdport.sv
// One registered read port of the nnrv register file, with a bypass from the
// write port so a read that coincides with a retiring write sees the new value.
module nnrv_regfile_rdport
  import nnrv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_en,
  input  reg_idx_t                    i_idx,
  input  logic [NREGS-1:0][XLEN-1:0]  i_rf,
  input  logic                        i_w_en,
  input  reg_idx_t                    i_w_idx,
  input  logic [XLEN-1:0]             i_w_data,
  output logic [XLEN-1:0]             o_data,
  output logic                        o_vld
);

  logic [XLEN-1:0] data_d, data_q;
  logic            vld_d,  vld_q;

  // Select the read result: x0, bypassed write data, or stored array content.
  // i_w_en is already qualified by the parent (never set for a write to x0).
  always_comb begin
    data_d = data_q;
    vld_d  = i_en;
    if (i_en) begin
      if (reg_is_zero(i_idx)) begin
        data_d = '0;
      end else if (i_w_en && (i_w_idx == i_idx)) begin
        data_d = i_w_data;
      end else if (int'(i_idx) < NREGS) begin
        data_d = i_rf[i_idx];
      end else begin
        data_d = '0;
      end
    end else begin
      data_d = data_q;
    end
  end

  // Output registers; data holds while no request is made.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      data_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  assign o_data = data_q;
  assign o_vld  = vld_q;

endmodule

// File: rtl/nnrv_regfile.sv
// Integer register file x0..x31 for the nnrv core: one writeback write port,
// two registered read ports with same-cycle write forwarding, x0 reads zero.
module nnrv_regfile
  import nnrv_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int NREGS = NREGS_DEF
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_reg_w_en,
  input  reg_idx_t        i_reg_w,
  input  logic [XLEN-1:0] i_reg_w_reg,
  input  logic            i_rs1_en,
  input  reg_idx_t        i_rs1,
  input  logic            i_rs2_en,
  input  reg_idx_t        i_rs2,
  output logic [XLEN-1:0] o_rs1_reg,
  output logic            o_rs1_vld,
  output logic [XLEN-1:0] o_rs2_reg,
  output logic            o_rs2_vld
);

  logic [NREGS-1:0][XLEN-1:0] mem_d, mem_q;
  logic                       wr_hit;

  assign wr_hit = i_reg_w_en && !reg_is_zero(i_reg_w) && (int'(i_reg_w) < NREGS);

  // Next array state: apply the qualified write, keep entry 0 pinned to zero.
  always_comb begin
    mem_d = mem_q;
    if (wr_hit) begin
      mem_d[i_reg_w] = i_reg_w_reg;
    end else begin
      mem_d = mem_q;
    end
    mem_d[0] = '0;
  end

  // Array flops; reset clears every entry and drops any concurrent write.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  nnrv_regfile_rdport #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_rdport1 (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (i_rs1_en),
    .i_idx    (i_rs1),
    .i_rf     (mem_q),
    .i_w_en   (wr_hit),
    .i_w_idx  (i_reg_w),
    .i_w_data (i_reg_w_reg),
    .o_data   (o_rs1_reg),
    .o_vld    (o_rs1_vld)
  );

  nnrv_regfile_rdport #(
    .XLEN  (XLEN),
    .NREGS (NREGS)
  ) u_rdport2 (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_en     (i_rs2_en),
    .i_idx    (i_rs2),
    .i_rf     (mem_q),
    .i_w_en   (wr_hit),
    .i_w_idx  (i_reg_w),
    .i_w_data (i_reg_w_reg),
    .o_data   (o_rs2_reg),
    .o_vld    (o_rs2_vld)
  );

endmodule

// File: tb/tb_nnrv_regfile.sv
// Self-checking bench for nnrv_regfile: directed scenarios plus randomized
// traffic against an architectural model of the register file.
module tb_nnrv_regfile;

  logic        i_clk;
  logic        i_rst;
  logic        i_reg_w_en;
  logic [4:0]  i_reg_w;
  logic [31:0] i_reg_w_reg;
  logic        i_rs1_en;
  logic [4:0]  i_rs1;
  logic        i_rs2_en;
  logic [4:0]  i_rs2;
  logic [31:0] o_rs1_reg;
  logic        o_rs1_vld;
  logic [31:0] o_rs2_reg;
  logic        o_rs2_vld;

  int checks = 0;
  int errors = 0;

  // Architectural model: register contents and the expected port outputs.
  logic [31:0] model [32];
  logic [31:0] exp_rs1, exp_rs2;
  logic        exp_vld1, exp_vld2;

  nnrv_regfile dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_reg_w_en  (i_reg_w_en),
    .i_reg_w     (i_reg_w),
    .i_reg_w_reg (i_reg_w_reg),
    .i_rs1_en    (i_rs1_en),
    .i_rs1       (i_rs1),
    .i_rs2_en    (i_rs2_en),
    .i_rs2       (i_rs2),
    .o_rs1_reg   (o_rs1_reg),
    .o_rs1_vld   (o_rs1_vld),
    .o_rs2_reg   (o_rs2_reg),
    .o_rs2_vld   (o_rs2_vld)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Drive one cycle of inputs, clock it, then advance the model: a read
  // observes the register state as it stands after that cycle's write.
  task automatic tick(input logic rst, input logic wen, input logic [4:0] w,
                      input logic [31:0] wd, input logic r1en, input logic [4:0] r1,
                      input logic r2en, input logic [4:0] r2);
    i_rst = rst; i_reg_w_en = wen; i_reg_w = w; i_reg_w_reg = wd;
    i_rs1_en = r1en; i_rs1 = r1; i_rs2_en = r2en; i_rs2 = r2;
    @(posedge i_clk);
    #1;
    if (rst) begin
      for (int k = 0; k < 32; k++) model[k] = 32'h0;
      exp_rs1 = 32'h0; exp_rs2 = 32'h0; exp_vld1 = 1'b0; exp_vld2 = 1'b0;
    end else begin
      if (wen && w != 5'd0) model[w] = wd;
      exp_vld1 = r1en;
      exp_vld2 = r2en;
      if (r1en) exp_rs1 = (r1 == 5'd0) ? 32'h0 : model[r1];
      if (r2en) exp_rs2 = (r2 == 5'd0) ? 32'h0 : model[r2];
    end
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
  endtask

  task automatic test_reset();
    tick(1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 1'b0, 5'd0);
    checks++;
    if (o_rs1_reg !== 32'h0 || o_rs2_reg !== 32'h0 || o_rs1_vld !== 1'b0 || o_rs2_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: rs1=%h rs2=%h vld1=%b vld2=%b, required all zero",
               o_rs1_reg, o_rs2_reg, o_rs1_vld, o_rs2_vld);
    end
    tick(1'b0, 1'b1, 5'd5, 32'hDEAD_BEEF, 1'b0, 5'd0, 1'b0, 5'd0);
    tick(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0);
    checks++;
    if (o_rs1_reg !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL reset_prewrite: got %h, required deadbeef", o_rs1_reg);
    end
    tick(1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b1, 5'd5);
    checks++;
    if (o_rs1_reg !== 32'h0 || o_rs1_vld !== 1'b0 || o_rs2_vld !== 1'b0) begin
      errors++;
      $display("FAIL reset_midop: rs1=%h vld1=%b vld2=%b, required 0/0/0", o_rs1_reg, o_rs1_vld, o_rs2_vld);
    end
    tick(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 1'b0, 5'd0);
    checks++;
    if (o_rs1_reg !== 32'h0 || o_rs1_vld !== 1'b1) begin
      errors++;
      $display("FAIL reset_x5_cleared: got %h vld=%b, required 0 vld=1", o_rs1_reg, o_rs1_vld);
    end
  endtask

  task automatic test_basic();
    tick(1'b0, 1'b1, 5'd1, 32'h1234_5678, 1'b0, 5'd0, 1'b0, 5'd0);
    tick(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd1, 1'b1, 5'd1);
    checks++;
    if (o_rs1_reg !== 32'h1234_5678 || o_rs2_reg !== 32'h1234_5678 || o_rs1_vld !== 1'b1 || o_rs2_vld !== 1'b1) begin
      errors++;
      $display("FAIL basic_read: rs1=%h rs2=%h vld=%b%b, required 12345678 both, vld 11",
               o_rs1_reg, o_rs2_reg, o_rs1_vld, o_rs2_vld);
    end
    idle();
    checks++;
    if (o_rs1_vld !== 1'b0 || o_rs2_vld !== 1'b0 || o_rs1_reg !== 32'h1234_5678) begin
      errors++;
      $display("FAIL basic_vld_pulse: vld=%b%b rs1=%h, required vld 00, rs1 held 12345678",
               o_rs1_vld, o_rs2_vld, o_rs1_reg);
    end
  endtask

  task automatic test_x0();
    tick(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b1, 5'd0, 1'b0, 5'd0);
    checks++;
    if (o_rs1_reg !== 32'h0 || o_rs1_vld !== 1'b1) begin
      errors++;
      $display("FAIL x0_same_cycle: got %h vld=%b, required 0 vld=1", o_rs1_reg, o_rs1_vld);
    end
    tick(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 1'b1, 5'd0);
    checks++;
    if (o_rs1_reg !== 32'h0 || o_rs2_reg !== 32'h0) begin
      errors++;
      $display("FAIL x0_later: rs1=%h rs2=%h, required 0 0", o_rs1_reg, o_rs2_reg);
    end
  endtask

  task automatic test_bypass();
    tick(1'b0, 1'b1, 5'd7, 32'h0000_0001, 1'b0, 5'd0, 1'b0, 5'd0);
    tick(1'b0, 1'b1, 5'd8, 32'h0000_0088, 1'b0, 5'd0, 1'b0, 5'd0);
    tick(1'b0, 1'b1, 5'd7, 32'hA5A5_A5A5, 1'b1, 5'd8, 1'b1, 5'd7);
    checks++;
    if (o_rs2_reg !== 32'hA5A5_A5A5 || o_rs2_vld !== 1'b1) begin
      errors++;
      $display("FAIL bypass_rs2: got %h vld=%b, required a5a5a5a5 vld=1", o_rs2_reg, o_rs2_vld);
    end
    checks++;
    if (o_rs1_reg !== 32'h0000_0088) begin
      errors++;
      $display("FAIL bypass_rs1_other: got %h, required 00000088", o_rs1_reg);
    end
    tick(1'b0, 1'b1, 5'd7, 32'h5A5A_0F0F, 1'b1, 5'd7, 1'b1, 5'd7);
    checks++;
    if (o_rs1_reg !== 32'h5A5A_0F0F || o_rs2_reg !== 32'h5A5A_0F0F) begin
      errors++;
      $display("FAIL bypass_both: rs1=%h rs2=%h, required 5a5a0f0f both", o_rs1_reg, o_rs2_reg);
    end
  endtask

  task automatic test_hold();
    tick(1'b0, 1'b1, 5'd3, 32'h0000_0033, 1'b0, 5'd0, 1'b0, 5'd0);
    tick(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd0);
    checks++;
    if (o_rs1_reg !== 32'h0000_0033) begin
      errors++;
      $display("FAIL hold_first_read: got %h, required 00000033", o_rs1_reg);
    end
    for (int c = 0; c < 3; c++) begin
      tick(1'b0, 1'b1, 5'd3, 32'h0000_0044, 1'b0, 5'd3, 1'b0, 5'd0);
      checks++;
      if (o_rs1_reg !== 32'h0000_0033 || o_rs1_vld !== 1'b0) begin
        errors++;
        $display("FAIL hold_cycle%0d: got %h vld=%b, required 00000033 vld=0", c, o_rs1_reg, o_rs1_vld);
      end
    end
    tick(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 1'b0, 5'd0);
    checks++;
    if (o_rs1_reg !== 32'h0000_0044 || o_rs1_vld !== 1'b1) begin
      errors++;
      $display("FAIL hold_reread: got %h vld=%b, required 00000044 vld=1", o_rs1_reg, o_rs1_vld);
    end
  endtask

  task automatic test_sweep();
    logic [31:0] want1, want2;
    for (int i = 1; i < 32; i++)
      tick(1'b0, 1'b1, 5'(i), 32'(i) * 32'h0101_0101, 1'b0, 5'd0, 1'b0, 5'd0);
    for (int i = 0; i < 32; i++) begin
      tick(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'(i), 1'b1, 5'(31 - i));
      want1 = 32'(i) * 32'h0101_0101;
      want2 = 32'(31 - i) * 32'h0101_0101;
      checks++;
      if (o_rs1_reg !== want1 || o_rs2_reg !== want2) begin
        errors++;
        $display("FAIL sweep_pair%0d: rs1=%h rs2=%h, required %h %h", i, o_rs1_reg, o_rs2_reg, want1, want2);
      end
    end
    tick(1'b1, 1'b1, 5'd9, 32'h0000_0099, 1'b0, 5'd0, 1'b0, 5'd0);
    tick(1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 1'b1, 5'd31);
    checks++;
    if (o_rs1_reg !== 32'h0 || o_rs2_reg !== 32'h0) begin
      errors++;
      $display("FAIL sweep_reset_write: x9=%h x31=%h, required 0 0", o_rs1_reg, o_rs2_reg);
    end
  endtask

  task automatic test_random();
    logic        rst, wen, r1en, r2en;
    logic [4:0]  w, r1, r2;
    logic [31:0] wd;
    for (int n = 0; n < 400; n++) begin
      rst  = ($urandom_range(0, 49) == 0);
      wen  = ($urandom_range(0, 3) != 0);
      w    = 5'($urandom_range(0, 31));
      wd   = $urandom;
      r1en = ($urandom_range(0, 3) != 0);
      r2en = ($urandom_range(0, 3) != 0);
      r1   = ($urandom_range(0, 2) == 0) ? w : 5'($urandom_range(0, 31));
      r2   = ($urandom_range(0, 2) == 0) ? w : 5'($urandom_range(0, 31));
      tick(rst, wen, w, wd, r1en, r1, r2en, r2);
      checks++;
      if (o_rs1_reg !== exp_rs1 || o_rs1_vld !== exp_vld1) begin
        errors++;
        $display("FAIL random_rs1 n=%0d: got %h vld=%b, required %h vld=%b", n, o_rs1_reg, o_rs1_vld, exp_rs1, exp_vld1);
      end
      checks++;
      if (o_rs2_reg !== exp_rs2 || o_rs2_vld !== exp_vld2) begin
        errors++;
        $display("FAIL random_rs2 n=%0d: got %h vld=%b, required %h vld=%b", n, o_rs2_reg, o_rs2_vld, exp_rs2, exp_vld2);
      end
    end
  endtask

  initial begin
    i_rst = 1'b1; i_reg_w_en = 1'b0; i_reg_w = 5'd0; i_reg_w_reg = 32'h0;
    i_rs1_en = 1'b0; i_rs1 = 5'd0; i_rs2_en = 1'b0; i_rs2 = 5'd0;
    test_reset();
    test_basic();
    test_x0();
    test_bypass();
    test_hold();
    test_sweep();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
